// File: rtl/aurora_pkg.sv
// Shared Aurora definitions: ordered-set classification, AXI word size and RX frame states.
package aurora_pkg;

    localparam int AXI_DATA_SIZE = 32;

    typedef enum logic [1:0] {SCP, ECP, DATA, IDLE} ordered_sets_e;

    typedef enum logic {RX_IDLE, RX_FRAME} rx_state_e;

endpackage

// File: rtl/rx_gearbox.sv
// Half/full-word assembler with a one-word hold buffer; a word leaves only once the
// following DATA or the closing ECP/SCP shows whether it is the last of its frame.
module rx_gearbox
    import aurora_pkg::*;
#(
    parameter int DATA_W = AXI_DATA_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                load,
    input  logic                flush,
    input  logic [DATA_W-1:0]   rx_data,
    output logic                axi_valid,
    output logic                axi_last,
    output logic [DATA_W/8-1:0] axi_keep,
    output logic [DATA_W-1:0]   axi_data
);

    localparam int HALF_W = DATA_W / 2;
    localparam int KEEP_W = DATA_W / 8;
    localparam logic [KEEP_W-1:0] KEEP_ALL   = '1;
    localparam logic [KEEP_W-1:0] KEEP_UPPER = {{(KEEP_W/2){1'b1}}, {(KEEP_W/2){1'b0}}};

    logic [DATA_W-1:0] hold_q;
    logic [KEEP_W-1:0] hold_keep_q;
    logic              hold_full;
    logic              word_done;
    logic              half_pending;
    logic              emit;

    // The lowest keep bit is set only once the held word is complete.
    assign word_done    = hold_full && hold_keep_q[0];
    assign half_pending = hold_full && !hold_keep_q[0];
    assign emit         = flush ? hold_full : (load && word_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full   <= 1'b0;
            hold_keep_q <= '0;
            axi_valid   <= 1'b0;
            axi_last    <= 1'b0;
            axi_keep    <= '0;
            axi_data    <= '0;
        end else begin
            axi_valid <= emit;
            axi_last  <= emit && flush;
            axi_keep  <= emit ? hold_keep_q : '0;
            if (emit)
                axi_data <= hold_q;

            if (flush) begin
                hold_full   <= 1'b0;
                hold_keep_q <= '0;
            end else if (load) begin
                hold_full   <= 1'b1;
                hold_keep_q <= (!mode || half_pending) ? KEEP_ALL : KEEP_UPPER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load && !flush) begin
            if (!mode)
                hold_q <= rx_data;
            else if (half_pending)
                hold_q[HALF_W-1:0] <= rx_data[HALF_W-1:0];
            else
                hold_q <= {rx_data[HALF_W-1:0], {HALF_W{1'b0}}};
        end
    end

endmodule

// File: rtl/rx_data_controller.sv
// Receive-side frame reassembly: frame FSM and protocol error detection in front of
// the gearbox that turns lane beats into AXI4-Stream words.
module rx_data_controller
    import aurora_pkg::*;
#(
    parameter int DATA_W = AXI_DATA_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                single_lane,
    input  logic                rx_valid,
    input  ordered_sets_e       rx_ordered_set,
    input  logic [DATA_W-1:0]   rx_data,
    output logic                axi_valid,
    output logic                axi_last,
    output logic [DATA_W/8-1:0] axi_keep,
    output logic [DATA_W-1:0]   axi_data,
    output logic                frame_err
);

    rx_state_e state;
    logic      mode_q;
    logic      load;
    logic      flush;

    // SCP inside a frame closes the current frame exactly like ECP does.
    always_comb begin
        load  = 1'b0;
        flush = 1'b0;
        if (rx_valid && state == RX_FRAME) begin
            load  = (rx_ordered_set == DATA);
            flush = (rx_ordered_set == ECP) || (rx_ordered_set == SCP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_IDLE;
            mode_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (rx_valid) begin
                case (state)
                    RX_IDLE: begin
                        case (rx_ordered_set)
                            SCP: begin
                                state  <= RX_FRAME;
                                mode_q <= single_lane;
                            end
                            DATA:    frame_err <= 1'b1;
                            default: ;
                        endcase
                    end
                    RX_FRAME: begin
                        case (rx_ordered_set)
                            SCP: begin
                                frame_err <= 1'b1;
                                mode_q    <= single_lane;
                            end
                            ECP:     state <= RX_IDLE;
                            default: ;
                        endcase
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    rx_gearbox #(
        .DATA_W (DATA_W)
    ) u_gearbox (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode_q),
        .load      (load),
        .flush     (flush),
        .rx_data   (rx_data),
        .axi_valid (axi_valid),
        .axi_last  (axi_last),
        .axi_keep  (axi_keep),
        .axi_data  (axi_data)
    );

endmodule

// File: tb/tb_rx_data_controller.sv
// Bench for rx_data_controller: directed frames plus random beats against a byte-queue frame model.
module tb_rx_data_controller;
    import aurora_pkg::*;

    localparam int DATA_W = 32;
    localparam int NB     = DATA_W / 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                single_lane;
    logic                rx_valid;
    ordered_sets_e       rx_ordered_set;
    logic [DATA_W-1:0]   rx_data;
    logic                axi_valid;
    logic                axi_last;
    logic [NB-1:0]       axi_keep;
    logic [DATA_W-1:0]   axi_data;
    logic                frame_err;

    int tests = 0;
    int fails = 0;

    // Reference model: an open/closed flag plus the not-yet-emitted bytes of the frame.
    bit          m_open;
    bit          m_single;
    logic [7:0]  m_bytes[$];
    logic        ev, el, ee;
    logic [NB-1:0]     ek;
    logic [DATA_W-1:0] ed;

    logic [DATA_W-1:0] words[$];
    bit                lasts[$];

    rx_data_controller #(.DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .single_lane    (single_lane),
        .rx_valid       (rx_valid),
        .rx_ordered_set (rx_ordered_set),
        .rx_data        (rx_data),
        .axi_valid      (axi_valid),
        .axi_last       (axi_last),
        .axi_keep       (axi_keep),
        .axi_data       (axi_data),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    function automatic void model_emit(bit last);
        int n;
        n  = (m_bytes.size() < NB) ? m_bytes.size() : NB;
        ev = 1'b1;
        el = last;
        ek = '0;
        ed = '0;
        for (int i = 0; i < n; i++) begin
            ed[DATA_W-1-8*i -: 8] = m_bytes.pop_front();
            ek[NB-1-i] = 1'b1;
        end
    endfunction

    function automatic void model_beat(bit v, ordered_sets_e os, bit single, logic [DATA_W-1:0] d);
        int nb;
        ev = 1'b0; el = 1'b0; ee = 1'b0; ek = '0; ed = '0;
        if (!v) return;
        case (os)
            SCP: begin
                if (m_open) begin
                    ee = 1'b1;
                    if (m_bytes.size() > 0) model_emit(1'b1);
                end
                m_bytes.delete();
                m_open   = 1'b1;
                m_single = single;
            end
            DATA: begin
                if (!m_open) ee = 1'b1;
                else begin
                    if (m_bytes.size() >= NB) model_emit(1'b0);
                    nb = m_single ? NB / 2 : NB;
                    for (int i = nb - 1; i >= 0; i--) m_bytes.push_back(d[8*i +: 8]);
                end
            end
            ECP: begin
                if (m_open) begin
                    if (m_bytes.size() > 0) model_emit(1'b1);
                    m_open = 1'b0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        m_open = 1'b0;
        m_bytes.delete();
    endfunction

    task automatic step(bit v, ordered_sets_e os, logic [DATA_W-1:0] d, bit single);
        @(negedge clk);
        rx_valid       = v;
        rx_ordered_set = os;
        rx_data        = d;
        single_lane    = single;
        @(posedge clk);
        #1;
        model_beat(v, os, single, d);
        if (axi_valid) begin
            words.push_back(axi_data);
            lasts.push_back(axi_last);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_ordered_set = IDLE; rx_data = '0; single_lane = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({axi_valid, axi_last, axi_keep, axi_data, frame_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h e=%b, expected all zero",
                     axi_valid, axi_last, axi_keep, axi_data, frame_err);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_dual_lane();
        ordered_sets_e os[4];
        logic [DATA_W-1:0] d[4];
        os = '{SCP, DATA, DATA, ECP};
        d  = '{32'h0, 32'h11223344, 32'h55667788, 32'h0};
        words.delete(); lasts.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, os[i], d[i], 1'b0);
            tests++;
            if (axi_valid !== ev || axi_last !== el || frame_err !== ee || (ev && (axi_keep !== ek || axi_data !== ed))) begin
                fails++;
                $display("FAIL dual_lane beat %0d: got v=%b l=%b e=%b k=%h d=%h, expected v=%b l=%b e=%b k=%h d=%h",
                         i, axi_valid, axi_last, frame_err, axi_keep, axi_data, ev, el, ee, ek, ed);
            end
        end
        step(1'b0, IDLE, '0, 1'b0);
        tests++;
        if (words.size() != 2) begin
            fails++;
            $display("FAIL dual_lane_words: got %0d words, expected 2", words.size());
        end else if (words[0] !== 32'h11223344 || words[1] !== 32'h55667788 || lasts[0] || !lasts[1]) begin
            fails++;
            $display("FAIL dual_lane_words: got %h/%0b %h/%0b, expected 11223344/0 55667788/1",
                     words[0], lasts[0], words[1], lasts[1]);
        end
    endtask

    task automatic test_single_lane();
        ordered_sets_e os[5];
        logic [DATA_W-1:0] d[5];
        os = '{SCP, DATA, DATA, DATA, ECP};
        d  = '{32'h0, 32'h0000AABB, 32'h0000CCDD, 32'h0000EEFF, 32'h0};
        words.delete(); lasts.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, os[i], d[i], 1'b1);
            tests++;
            if (axi_valid !== ev || axi_last !== el || frame_err !== ee || (ev && (axi_keep !== ek || axi_data !== ed))) begin
                fails++;
                $display("FAIL single_lane beat %0d: got v=%b l=%b e=%b k=%h d=%h, expected v=%b l=%b e=%b k=%h d=%h",
                         i, axi_valid, axi_last, frame_err, axi_keep, axi_data, ev, el, ee, ek, ed);
            end
        end
        tests++;
        if (words.size() != 2) begin
            fails++;
            $display("FAIL single_lane_words: got %0d words, expected 2", words.size());
        end else if (words[0] !== 32'hAABBCCDD || words[1] !== 32'hEEFF0000 || !lasts[1]) begin
            fails++;
            $display("FAIL single_lane_words: got %h %h last=%0b, expected AABBCCDD EEFF0000 last=1",
                     words[0], words[1], lasts[1]);
        end
    endtask

    task automatic test_idle_in_frame();
        ordered_sets_e os[8];
        logic [DATA_W-1:0] d[8];
        bit v[8];
        os = '{SCP, DATA, IDLE, IDLE, DATA, IDLE, DATA, ECP};
        d  = '{32'h0, 32'h01020304, 32'h0, 32'h0, 32'h0BADF00D, 32'h0, 32'h05060708, 32'h0};
        v  = '{1, 1, 1, 1, 0, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            step(v[i], os[i], d[i], 1'b0);
            tests++;
            if (axi_valid !== ev || axi_last !== el || frame_err !== ee || (ev && (axi_keep !== ek || axi_data !== ed))) begin
                fails++;
                $display("FAIL idle_in_frame beat %0d: got v=%b l=%b e=%b k=%h d=%h, expected v=%b l=%b e=%b k=%h d=%h",
                         i, axi_valid, axi_last, frame_err, axi_keep, axi_data, ev, el, ee, ek, ed);
            end
        end
    endtask

    task automatic test_empty_and_stray();
        ordered_sets_e os[5];
        os = '{SCP, ECP, DATA, ECP, IDLE};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, os[i], 32'h13579BDF, 1'b0);
            tests++;
            if (axi_valid !== ev || axi_last !== el || frame_err !== ee || (ev && (axi_keep !== ek || axi_data !== ed))) begin
                fails++;
                $display("FAIL empty_and_stray beat %0d: got v=%b l=%b e=%b, expected v=%b l=%b e=%b",
                         i, axi_valid, axi_last, frame_err, ev, el, ee);
            end
        end
    endtask

    task automatic test_scp_in_frame();
        ordered_sets_e os[5];
        logic [DATA_W-1:0] d[5];
        os = '{SCP, DATA, SCP, DATA, ECP};
        d  = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hCAFEF00D, 32'h0};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, os[i], d[i], 1'b0);
            tests++;
            if (axi_valid !== ev || axi_last !== el || frame_err !== ee || (ev && (axi_keep !== ek || axi_data !== ed))) begin
                fails++;
                $display("FAIL scp_in_frame beat %0d: got v=%b l=%b e=%b k=%h d=%h, expected v=%b l=%b e=%b k=%h d=%h",
                         i, axi_valid, axi_last, frame_err, axi_keep, axi_data, ev, el, ee, ek, ed);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        ordered_sets_e os[3];
        logic [DATA_W-1:0] d[3];
        os = '{SCP, DATA, DATA};
        d  = '{32'h0, 32'h12345678, 32'h87654321};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, os[i], d[i], 1'b0);
            tests++;
            if (axi_valid !== ev || axi_last !== el || frame_err !== ee || (ev && (axi_keep !== ek || axi_data !== ed))) begin
                fails++;
                $display("FAIL reset_mid_frame beat %0d: got v=%b l=%b e=%b k=%h d=%h, expected v=%b l=%b e=%b k=%h d=%h",
                         i, axi_valid, axi_last, frame_err, axi_keep, axi_data, ev, el, ee, ek, ed);
            end
        end
        #1;
        rst = 1'b1;
        rx_valid = 1'b0;
        #1;
        tests++;
        if ({axi_valid, axi_last, axi_keep, axi_data, frame_err} !== '0) begin
            fails++;
            $display("FAIL async_reset: got v=%b l=%b k=%h d=%h e=%b, expected all zero",
                     axi_valid, axi_last, axi_keep, axi_data, frame_err);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        words.delete(); lasts.delete();
        os = '{SCP, DATA, ECP};
        d  = '{32'h0, 32'h9ABCDEF0, 32'h0};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, os[i], d[i], 1'b0);
            tests++;
            if (axi_valid !== ev || axi_last !== el || frame_err !== ee || (ev && (axi_keep !== ek || axi_data !== ed))) begin
                fails++;
                $display("FAIL after_reset beat %0d: got v=%b l=%b e=%b k=%h d=%h, expected v=%b l=%b e=%b k=%h d=%h",
                         i, axi_valid, axi_last, frame_err, axi_keep, axi_data, ev, el, ee, ek, ed);
            end
        end
        tests++;
        if (words.size() != 1 || words[0] !== 32'h9ABCDEF0 || !lasts[0]) begin
            fails++;
            $display("FAIL after_reset_words: got %0d words (first %h), expected only 9ABCDEF0 last",
                     words.size(), (words.size() > 0) ? words[0] : 32'h0);
        end
    endtask

    task automatic test_random();
        ordered_sets_e os;
        int r;
        bit v;
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 9);
            os = (r == 0) ? SCP : (r == 1) ? ECP : (r == 2) ? IDLE : DATA;
            v  = ($urandom_range(0, 7) != 0);
            step(v, os, $urandom, 1'($urandom_range(0, 1)));
            tests++;
            if (axi_valid !== ev || axi_last !== el || frame_err !== ee || (ev && (axi_keep !== ek || axi_data !== ed))) begin
                fails++;
                $display("FAIL random beat %0d: got v=%b l=%b e=%b k=%h d=%h, expected v=%b l=%b e=%b k=%h d=%h",
                         i, axi_valid, axi_last, frame_err, axi_keep, axi_data, ev, el, ee, ek, ed);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_dual_lane();
        test_single_lane();
        test_idle_in_frame();
        test_empty_and_stray();
        test_scp_in_frame();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
